// File: rtl/uart_ram_loader_pkg.sv
// Shared state encoding, framing byte defaults and length decode for the UART RAM loader.
package uart_ram_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AHI,
    S_ALO,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_RESP
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] ACK_BYTE_DEF  = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF  = 8'h15;

  // A length byte of zero stands for a full 256-byte payload.
  function automatic logic [8:0] len_decode(input logic [7:0] len);
    return (len == 8'h00) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle counter: clears on activity or when not running; o_expire is combinational on the last idle cycle.
// No backpressure; one count per clock.
module loader_timeout #(
  parameter int TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_run && !i_clr && (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_run) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_ram_loader.sv
// Frame parser feeding RAM port B; each payload byte is written the cycle after it arrives, the response waits on tx_ready.
// Accepts one byte per clock; rx bytes arriving while a response is pending are dropped.
module uart_ram_loader
  import uart_ram_loader_pkg::*;
#(
  parameter int         ADDR_W    = 11,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE  = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE  = NAK_BYTE_DEF,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [7:0]        o_ram_data,
  output logic              o_ram_we,
  output logic              o_cpu_hold,
  output logic              o_frame_done,
  output logic              o_frame_err
);

  state_t              r_state, w_state;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [8:0]          r_cnt, w_cnt;
  logic [7:0]          r_sum, w_sum;
  logic [7:0]          r_tx_data, w_tx_data;
  logic                r_tx_valid, w_tx_valid;
  logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr;
  logic [7:0]          r_ram_data, w_ram_data;
  logic                r_ram_we, w_ram_we;
  logic                r_cpu_hold, w_cpu_hold;
  logic                r_done, w_done;
  logic                r_err, w_err;
  logic                w_run, w_timeout;
  logic [7:0]          w_sum_add;

  assign w_run     = (r_state != S_IDLE) && (r_state != S_RESP);
  assign w_sum_add = r_sum + i_rx_data;

  loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (w_run),
    .i_clr    (i_rx_valid),
    .o_expire (w_timeout)
  );

  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_cnt      = r_cnt;
    w_sum      = r_sum;
    w_tx_data  = r_tx_data;
    w_tx_valid = r_tx_valid;
    w_ram_addr = r_ram_addr;
    w_ram_data = r_ram_data;
    w_ram_we   = 1'b0;
    w_cpu_hold = r_cpu_hold;
    w_done     = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      S_IDLE: if (i_rx_valid && i_rx_data == SYNC_BYTE) begin
        w_state    = S_AHI;
        w_cpu_hold = 1'b1;
        w_sum      = 8'h00;
      end
      S_AHI: if (i_rx_valid) begin
        // Upper address bits beyond the RAM size are silently dropped.
        w_addr[ADDR_W-1:8] = i_rx_data[ADDR_W-9:0];
        w_sum              = w_sum_add;
        w_state            = S_ALO;
      end
      S_ALO: if (i_rx_valid) begin
        w_addr[7:0] = i_rx_data;
        w_sum       = w_sum_add;
        w_state     = S_LEN;
      end
      S_LEN: if (i_rx_valid) begin
        w_cnt   = len_decode(i_rx_data);
        w_sum   = w_sum_add;
        w_state = S_DATA;
      end
      S_DATA: if (i_rx_valid) begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_addr;
        w_ram_data = i_rx_data;
        w_addr     = r_addr + ADDR_W'(1);
        w_cnt      = r_cnt - 9'd1;
        w_sum      = w_sum_add;
        if (r_cnt == 9'd1) w_state = S_CSUM;
      end
      S_CSUM: if (i_rx_valid) begin
        w_tx_valid = 1'b1;
        w_state    = S_RESP;
        if (w_sum_add == 8'h00) begin
          w_tx_data = ACK_BYTE;
          w_done    = 1'b1;
        end else begin
          w_tx_data = NAK_BYTE;
          w_err     = 1'b1;
        end
      end
      S_RESP: if (i_tx_ready) begin
        w_tx_valid = 1'b0;
        w_cpu_hold = 1'b0;
        w_state    = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    // Expiry only fires on a cycle without rx_valid, so it never competes with a byte capture.
    if (w_timeout) begin
      w_state    = S_RESP;
      w_tx_data  = NAK_BYTE;
      w_tx_valid = 1'b1;
      w_err      = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= '0;
      r_ram_we   <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_cnt      <= w_cnt;
      r_sum      <= w_sum;
      r_tx_data  <= w_tx_data;
      r_tx_valid <= w_tx_valid;
      r_ram_addr <= w_ram_addr;
      r_ram_data <= w_ram_data;
      r_ram_we   <= w_ram_we;
      r_cpu_hold <= w_cpu_hold;
      r_done     <= w_done;
      r_err      <= w_err;
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_valid   = r_tx_valid;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_data   = r_ram_data;
  assign o_ram_we     = r_ram_we;
  assign o_cpu_hold   = r_cpu_hold;
  assign o_frame_done = r_done;
  assign o_frame_err  = r_err;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: table of frames plus hand sequences for timeout and mid-frame reset.
module tb_uart_ram_loader;

  localparam int ADDR_W = 11;
  localparam int TO     = 40;

  logic              clk = 1'b0;
  logic              i_rst;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [7:0]        o_ram_data;
  logic              o_ram_we;
  logic              o_cpu_hold;
  logic              o_frame_done;
  logic              o_frame_err;

  always #5 clk = ~clk;

  uart_ram_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .o_ram_addr   (o_ram_addr),
    .o_ram_data   (o_ram_data),
    .o_ram_we     (o_ram_we),
    .o_cpu_hold   (o_cpu_hold),
    .o_frame_done (o_frame_done),
    .o_frame_err  (o_frame_err)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  typedef struct {
    logic [7:0] ahi, alo, len, seed, step, csum, exp_resp;
    logic       exp_done, exp_err;
  } frame_vec_t;

  wr_t        wr_q[$];
  logic [7:0] resp_q[$];
  wr_t        mon_e;
  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0;
  int base_done = 0, base_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write scoreboard and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (o_frame_done === 1'b1) done_cnt++;
    if (o_frame_err === 1'b1) err_cnt++;
    if (o_ram_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        check("unexpected_we", 32'(o_ram_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = wr_q.pop_front();
        check("we_addr", 32'(o_ram_addr), 32'(mon_e.addr));
        check("we_data", 32'(o_ram_data), 32'(mon_e.data));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    @(negedge clk);
  endtask

  task automatic rx_idle();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {o_tx_data, o_tx_valid, o_ram_addr, o_ram_data, o_ram_we,
                 o_cpu_hold, o_frame_done, o_frame_err}, 32'd0);
  endtask

  task automatic start_frame(input logic [7:0] ahi, input logic [7:0] alo, input logic [7:0] len);
    base_done = done_cnt;
    base_err  = err_cnt;
    check("hold_before_sync", 32'(o_cpu_hold), 32'd0);
    send_byte(8'hA5);
    check("hold_after_sync", 32'(o_cpu_hold), 32'd1);
    send_byte(ahi);
    send_byte(alo);
    send_byte(len);
  endtask

  task automatic wait_resp(input int exp_done, input int exp_err);
    int n = 0;
    int hold;
    logic [7:0] exp = 8'h00;
    while (o_tx_valid !== 1'b1 && n < TO * 4) begin
      @(negedge clk);
      n++;
    end
    check("resp_wait", (n < TO * 4) ? 32'd1 : 32'd0, 32'd1);
    if (resp_q.size() == 0) check("resp_queue", 32'd0, 32'd1);
    else exp = resp_q.pop_front();
    check("tx_data", 32'(o_tx_data), 32'(exp));
    check("hold_in_resp", 32'(o_cpu_hold), 32'd1);
    hold = $urandom_range(1, 3);
    for (int k = 0; k < hold; k++) begin
      // A SYNC arriving during the response must be dropped.
      if (k == 0) begin
        i_rx_valid = 1'b1;
        i_rx_data  = 8'hA5;
      end
      @(negedge clk);
      rx_idle();
    end
    check("tx_valid_held", 32'(o_tx_valid), 32'd1);
    i_tx_ready = 1'b1;
    @(negedge clk);
    i_tx_ready = 1'b0;
    check("tx_valid_drop", 32'(o_tx_valid), 32'd0);
    check("hold_cleared", 32'(o_cpu_hold), 32'd0);
    check("done_pulses", 32'(done_cnt - base_done), 32'(exp_done));
    check("err_pulses", 32'(err_cnt - base_err), 32'(exp_err));
  endtask

  task automatic send_frame(input frame_vec_t v);
    int n = (v.len == 8'h00) ? 256 : int'(v.len);
    logic [ADDR_W-1:0] a = {v.ahi[2:0], v.alo};
    logic [7:0] d = v.seed;
    start_frame(v.ahi, v.alo, v.len);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back('{addr: a, data: d});
      send_byte(d);
      a = a + 11'd1;
      d = d + v.step;
    end
    resp_q.push_back(v.exp_resp);
    send_byte(v.csum);
    rx_idle();
    wait_resp(int'(v.exp_done), int'(v.exp_err));
  endtask

  frame_vec_t vecs[5];
  int k;

  initial begin
    //           ahi    alo    len    seed   step   csum   resp   done  err
    vecs[0] = '{8'h00, 8'h10, 8'h03, 8'h11, 8'h11, 8'h87, 8'h06, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 8'h10, 8'h03, 8'h11, 8'h11, 8'h00, 8'h15, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h02, 8'hA0, 8'h11, 8'hAF, 8'h06, 1'b1, 1'b0};
    vecs[3] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h7E, 8'h06, 1'b1, 1'b0};
    vecs[4] = '{8'h03, 8'hFE, 8'h05, 8'h10, 8'h10, 8'h0B, 8'h15, 1'b0, 1'b1};

    i_rst      = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    i_tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    i_rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) send_frame(vecs[i]);

    // Idle timeout after two payload bytes; the written bytes stay.
    start_frame(8'h00, 8'h40, 8'h05);
    wr_q.push_back('{addr: 11'h040, data: 8'hC1});
    send_byte(8'hC1);
    wr_q.push_back('{addr: 11'h041, data: 8'hC2});
    send_byte(8'hC2);
    rx_idle();
    for (k = 1; k <= TO + 10; k++) begin
      @(negedge clk);
      if (o_frame_err === 1'b1) break;
    end
    check("timeout_cycles", 32'(k), 32'(TO));
    resp_q.push_back(8'h15);
    wait_resp(0, 1);
    send_frame(vecs[0]);

    // Reset lands together with the second payload byte, whose write must never appear.
    start_frame(8'h01, 8'h00, 8'h04);
    wr_q.push_back('{addr: 11'h100, data: 8'h51});
    send_byte(8'h51);
    i_rx_valid = 1'b1;
    i_rx_data  = 8'h52;
    i_rst      = 1'b1;
    @(negedge clk);
    rx_idle();
    check_all_zero("mid_frame_reset");
    i_rst = 1'b0;
    send_byte(8'h42);
    rx_idle();
    check("ignore_non_sync", 32'(o_cpu_hold), 32'd0);
    @(negedge clk);
    send_frame(vecs[2]);

    repeat (3) @(negedge clk);
    check("writes_drained", 32'(wr_q.size()), 32'd0);
    check("resps_drained", 32'(resp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
